// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and the future receiver).
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // data_bits encoding: number of data bits is code + 5
  localparam logic [1:0] DataBits5 = 2'd0;
  localparam logic [1:0] DataBits6 = 2'd1;
  localparam logic [1:0] DataBits7 = 2'd2;
  localparam logic [1:0] DataBits8 = 2'd3;

  function automatic int unsigned def_div(input int unsigned clk_mhz, input int unsigned baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] nbits,
                                      input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nbits) + 5) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count; read data is the head entry (show-ahead).
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0] CntOne = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with input FIFO; line format and baud divisor are latched per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(def_div(CLK_FRE, BAUD_RATE));
  localparam logic [DIV_W-1:0] One    = DIV_W'(1);

  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;

  tx_state_e        state;
  logic [DIV_W-1:0] cnt, div_q, eff_div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [1:0]       nbits_q;
  logic             par_en_q, par_q, stop2_q;
  logic             bit_end, last_data, stop_done;

  assign tx_data_ready = !fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_data_valid && !fifo_full),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    eff_div = baud_div;
    if (baud_div == '0)     eff_div = DefDiv;
    else if (baud_div == One) eff_div = DIV_W'(2);
  end

  assign bit_end   = (cnt == div_q - One);
  // last data bit index is N-1 = code + 4
  assign last_data = (bit_cnt == {1'b1, nbits_q});
  assign stop_done = !stop2_q || bit_cnt[0];
  assign fifo_pop  = !fifo_empty &&
                     ((state == StIdle) || ((state == StStop) && bit_end && stop_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      tx_pin   <= 1'b1;
      tx_busy  <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      div_q    <= DIV_W'(2);
      nbits_q  <= DataBits8;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (fifo_pop) begin
      // frame start: pop and snapshot the whole line configuration
      state    <= StStart;
      tx_pin   <= 1'b0;
      tx_busy  <= 1'b1;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= fifo_rdata;
      div_q    <= eff_div;
      nbits_q  <= data_bits;
      par_en_q <= parity_en;
      par_q    <= parity_bit(fifo_rdata, data_bits, parity_odd);
      stop2_q  <= stop2;
    end else if (state != StIdle) begin
      if (!bit_end) begin
        cnt <= cnt + One;
      end else begin
        cnt <= '0;
        unique case (state)
          StStart: begin
            state   <= StData;
            tx_pin  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
          StData: begin
            if (last_data) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state  <= StParity;
                tx_pin <= par_q;
              end else begin
                state  <= StStop;
                tx_pin <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_pin  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          StParity: begin
            state  <= StStop;
            tx_pin <= 1'b1;
          end
          StStop: begin
            if (!stop_done) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              state   <= StIdle;
              tx_busy <= 1'b0;
              tx_pin  <= 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench: serial-line monitor against a scoreboard of queued frames.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, stop2;
  logic        tx_pin, tx_busy;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .CLK_FRE    (1),
    .BAUD_RATE  (125000),
    .DIV_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .baud_div      (baud_div),
    .data_bits     (data_bits),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .stop2         (stop2),
    .tx_pin        (tx_pin),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  db;
    logic        pe, po, s2;
    logic [15:0] div;
  } frame_t;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  db;
    logic        pe, po, s2;
    logic [15:0] div;
    int          exp_len;
    logic [7:0]  exp_data;
    logic        exp_par;
  } vec_t;

  frame_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t cur_cfg(input logic [7:0] w);
    frame_t f;
    f.data = w; f.db = data_bits; f.pe = parity_en; f.po = parity_odd;
    f.s2 = stop2; f.div = baud_div;
    return f;
  endfunction

  // ---------------- serial line monitor ----------------
  frame_t      mon_cur;
  logic [15:0] exp_bits;
  logic [7:0]  cap_data;
  logic        cap_par;
  bit          mon_active = 0;
  bit          bit_bad;
  int          flen, nb, bit_i, cyc, d;
  int          frames_done = 0, busy_cycles = 0, gap = 0, nz_gaps = 0, tx_low_cycles = 0;

  always @(negedge clk) begin
    if (tx_busy) busy_cycles++;
    if (!tx_pin) tx_low_cycles++;
    if (!rst_n) begin
      mon_active = 0;
      gap = 0;
    end else begin
      if (!mon_active) begin
        if (!tx_pin) begin
          if (sb.size() == 0) begin
            check("unexpected_start", 1, 0);
          end else begin
            mon_cur = sb.pop_front();
            nb = int'(mon_cur.db) + 5;
            flen = 1 + nb + int'(mon_cur.pe) + 1 + int'(mon_cur.s2);
            d = (mon_cur.div == 0) ? 8 : (mon_cur.div == 1) ? 2 : int'(mon_cur.div);
            exp_bits = '1;
            exp_bits[0] = 1'b0;
            for (int i = 0; i < nb; i++) exp_bits[1+i] = mon_cur.data[i];
            if (mon_cur.pe) exp_bits[nb+1] = (^(mon_cur.data & (8'hFF >> (8 - nb)))) ^ mon_cur.po;
            mon_active = 1; bit_i = 0; cyc = 0; bit_bad = 0; cap_data = '0; cap_par = 1'b0;
            if (gap > 0) nz_gaps++;
            gap = 0;
          end
        end else begin
          gap++;
        end
      end
      if (mon_active) begin
        if (tx_pin !== exp_bits[bit_i] || tx_busy !== 1'b1) bit_bad = 1;
        if (cyc == 0 && bit_i >= 1 && bit_i <= nb) cap_data[bit_i-1] = tx_pin;
        if (cyc == 0 && mon_cur.pe && bit_i == nb + 1) cap_par = tx_pin;
        if (cyc == d - 1) begin
          check($sformatf("frame%0d_bit%0d_bad", frames_done, bit_i), bit_bad, 0);
          bit_bad = 0;
          cyc = 0;
          bit_i++;
          if (bit_i == flen) begin
            mon_active = 0;
            frames_done++;
          end
        end else begin
          cyc++;
        end
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frame_wait_done", frames_done >= target, 1);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po, input logic s2,
                         input logic [15:0] div);
    data_bits = db; parity_en = pe; parity_odd = po; stop2 = s2; baud_div = div;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vecs[6];
  logic [7:0]  words[6];
  int          f0, b0, nz0, guard, k, low0;
  bit          r, stall_seen;
  frame_t      fb;

  initial begin
    vecs[0] = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b0, 16'd6, 60, 8'h35, 1'b0};
    vecs[1] = '{8'h35, 2'd2, 1'b1, 1'b1, 1'b0, 16'd6, 60, 8'h35, 1'b1};
    vecs[2] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 16'd0, 64, 8'h1F, 1'b0};
    vecs[3] = '{8'h2C, 2'd1, 1'b1, 1'b1, 1'b1, 16'd1, 20, 8'h2C, 1'b0};
    vecs[4] = '{8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 16'd3, 33, 8'h00, 1'b0};
    vecs[5] = '{8'hC3, 2'd3, 1'b1, 1'b1, 1'b1, 16'd5, 60, 8'hC3, 1'b1};
    words = '{8'h11, 8'h22, 8'h5A, 8'h81, 8'hF0, 8'h3C};

    tx_data = '0; tx_data_valid = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    repeat (3) @(negedge clk);
    check("rst_tx_pin", tx_pin, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_ready", tx_data_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 div 4, 0xA5: start at E1, 40-clock frame
    f0 = frames_done; b0 = busy_cycles;
    tx_data = 8'hA5; tx_data_valid = 1'b1; sb.push_back(cur_cfg(8'hA5));
    @(negedge clk);
    tx_data_valid = 1'b0;
    check("e0_level", fifo_level, 1);
    check("e0_tx_pin", tx_pin, 1);
    @(negedge clk);
    check("e1_tx_pin", tx_pin, 0);
    check("e1_busy", tx_busy, 1);
    check("e1_level", fifo_level, 0);
    wait_frames(f0 + 1, 200);
    check("a5_len", busy_cycles - b0, 40);
    check("a5_data", cap_data, 8'hA5);
    @(negedge clk);
    check("a5_busy_after", tx_busy, 0);

    // table of line formats
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].db, vecs[v].pe, vecs[v].po, vecs[v].s2, vecs[v].div);
      repeat (2) @(negedge clk);
      f0 = frames_done; b0 = busy_cycles;
      tx_data = vecs[v].data; tx_data_valid = 1'b1; sb.push_back(cur_cfg(vecs[v].data));
      @(negedge clk);
      tx_data_valid = 1'b0;
      wait_frames(f0 + 1, 300);
      check($sformatf("vec%0d_len", v), busy_cycles - b0, vecs[v].exp_len);
      check($sformatf("vec%0d_data", v), cap_data, vecs[v].exp_data);
      if (vecs[v].pe) check($sformatf("vec%0d_parity", v), cap_par, vecs[v].exp_par);
    end

    // back-to-back burst with valid held high
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd2);
    repeat (3) @(negedge clk);
    f0 = frames_done; nz0 = nz_gaps; k = 0; guard = 0; stall_seen = 0;
    tx_data = words[0]; tx_data_valid = 1'b1;
    while (k < 6 && guard < 200) begin
      r = tx_data_ready;
      if (r) begin
        sb.push_back(cur_cfg(words[k]));
      end else if (!stall_seen) begin
        check("burst_stall_ready", tx_data_ready, 0);
        check("burst_stall_level", fifo_level, 4);
        stall_seen = 1;
      end
      @(negedge clk);
      guard++;
      if (r) begin
        k++;
        if (k < 6) tx_data = words[k];
      end
    end
    tx_data_valid = 1'b0;
    check("burst_stall_seen", stall_seen, 1);
    check("burst_all_pushed", k, 6);
    wait_frames(f0 + 6, 400);
    check("burst_idle_gaps", nz_gaps - nz0, 1);

    // config change mid-frame only affects the following frame
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    repeat (3) @(negedge clk);
    f0 = frames_done; b0 = busy_cycles;
    tx_data = 8'h96; tx_data_valid = 1'b1; sb.push_back(cur_cfg(8'h96));
    @(negedge clk);
    fb = cur_cfg(8'hB7); fb.db = 2'd1; fb.div = 16'd3;
    tx_data = 8'hB7; sb.push_back(fb);
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (10) @(negedge clk);
    data_bits = 2'd1; baud_div = 16'd3;
    wait_frames(f0 + 2, 300);
    check("midcfg_total_len", busy_cycles - b0, 64);
    check("midcfg_second_data", cap_data, 8'h37);

    // asynchronous reset mid-data with three words queued
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tx_data = words[i]; tx_data_valid = 1'b1; sb.push_back(cur_cfg(words[i]));
      @(negedge clk);
    end
    tx_data_valid = 1'b0;
    check("pre_rst_level", fifo_level, 3);
    repeat (8) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_pin", tx_pin, 1);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_ready", tx_data_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    f0 = frames_done; low0 = tx_low_cycles;
    repeat (100) @(negedge clk);
    check("post_rst_frames", frames_done, f0);
    check("post_rst_low_cycles", tx_low_cycles - low0, 0);
    check("post_rst_busy", tx_busy, 0);
    check("post_rst_level", fifo_level, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter with a small input FIFO and per-frame runtime configuration: 5–8 data bits, parity none/even/odd, 1 or 2 stop bits, and a runtime baud divisor. Sits between a byte-stream producer (valid/ready) and the serial pin. It replaces the fixed 8N1, compile-time-baud transmitter in designs that need multiple line formats or back-to-back streaming.

Parameters:
CLK_FRE, 50, clock frequency in MHz; used only for DEF_DIV
BAUD_RATE, 115200, default baud; DEF_DIV = CLK_FRE*1000000/BAUD_RATE
DIV_W, 16, width of baud divisor
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tx_data  in  8  data word; unused upper bits ignored
tx_data_valid  in  1  producer has a word
tx_data_ready  out  1  FIFO can accept; equals !full
baud_div  in  DIV_W  clocks per bit; 0 selects DEF_DIV; 1 is treated as 2
data_bits  in  2  0:5, 1:6, 2:7, 3:8 data bits
parity_en  in  1  append parity bit
parity_odd  in  1  1 odd, 0 even (ignored if !parity_en)
stop2  in  1  1: two stop bits
tx_pin  out  1  serial output, registered, idles high
tx_busy  out  1  FSM not in IDLE
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset (async): tx_pin=1, tx_busy=0, FIFO flushed, fifo_level=0, tx_data_ready=1 (combinational from FIFO state), FSM=IDLE, counters=0. Reset mid-frame aborts the frame; tx_pin returns high immediately.
- Push: a word is written on the clk edge where tx_data_valid && tx_data_ready. When full, ready=0 and valid is ignored.
- Simultaneous push and pop leaves fifo_level unchanged. Push into an empty FIFO cannot be popped in the same cycle; it is first visible one cycle later.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on any edge with FIFO non-empty. On that edge: pop, latch the word, and latch baud_div, data_bits, parity_en, parity_odd and stop2 into frame registers. tx_pin<=0 on the same edge. Latency: word accepted at edge E0 into empty FIFO while idle -> tx_pin falls at E1.
- Config inputs and baud_div changing mid-frame have no effect until the next frame start.
- Each bit lasts exactly D clocks, D = effective latched divisor. The cycle counter counts 0..D-1 and wraps to 0 at each bit boundary.
- START (1 bit) -> DATA.
- DATA: bits sent LSB first, N = 5..8 bits. After bit N-1 go to PARITY if parity_en, else STOP.
- PARITY (1 bit): value = XOR of the N data bits, inverted if parity_odd. -> STOP.
- STOP: tx_pin=1 for 1 bit, or 2 bits if stop2.
- At the end of the last stop bit: if the FIFO is non-empty, go directly to START (pop and latch on that edge, no idle cycle). Otherwise go to IDLE.
- Frame length = D*(1+N+parity_en+1+stop2) clocks exactly.
- tx_busy=1 from the START entry edge through the last stop-bit cycle.
- Counter widths: cycle counter DIV_W bits; bit counter 3 bits; no overflow is possible by construction.

Decomposition:
- Shared package uart_pkg: FSM state enum; data_bits encoding constants; parity function (data, nbits, odd) -> bit; DEF_DIV computation function.
- Sub-module uart_tx_fifo: synchronous FIFO, DEPTH/width parameters, push/pop/full/empty/level, async active-low reset. Reusable by the future uart_rx.
- Top level holds the FSM, baud counter, bit counter and frame registers.

Test Plan:
- 8N1, baud_div=4, push 0xA5 while idle: tx_pin low at E1, then data bits 1,0,1,0,0,1,0,1, one high stop bit. Each bit is 4 clocks, frame is 40 clocks, then tx_busy=0.
- 7E1, baud_div=6, push 0x35: 7 data bits 1,0,1,0,1,1,0 then parity 0; repeat with parity_odd=1 and expect parity 1. Frame is 60 clocks.
- 5 data bits, no parity, stop2=1, baud_div=0 (CLK_FRE=1, BAUD_RATE=125000 -> DEF_DIV=8), push 0xFF: five 1 bits then two stop bits. Frame is 64 clocks; upper data bits are ignored.
- FIFO_DEPTH=4, valid held high with 6 words from idle: word 1 pops at E1 and words 2–5 fill the FIFO. Ready=0 and fifo_level=4 while word 6 is stalled. All frames go out back-to-back, with a START immediately after each final stop bit and no idle cycle.
- Change data_bits and baud_div mid-frame: the current frame is unaffected and the next frame uses the new values.
- Assert rst_n low mid-DATA with 3 words queued: tx_pin=1, tx_busy=0 and fifo_level=0 immediately. After release, no frame is sent until a new push.
